// File: rtl/switch_port_rx.sv
// Ingress receiver for one switch port: checks packet headers, stores legal packets
// in a local FIFO and presents them to the fabric on a valid/ready stream.
// Optional feature macro: SWITCH_RX_STATS_EN adds pkt_cnt/byte_cnt statistics outputs.
module switch_port_rx #(
    parameter int PORT_ID    = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int DW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sop,
    input  logic          in_eop,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic          out_sop,
    output logic          out_eop,
    output logic          out_err,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [7:0]    drop_cnt,
    output logic          err_pulse
`ifdef SWITCH_RX_STATS_EN
    ,
    output logic [15:0]   pkt_cnt,
    output logic [31:0]   byte_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic          err;
        logic          eop;
        logic          sop;
        logic [DW-1:0] data;
    } entry_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          err_pulse_q, err_pulse_d;
    entry_t        mem [FIFO_DEPTH];
    entry_t        wr_entry, head;
    logic          accept, push, pop, hdr_legal, drop_evt, err_evt, legal_eop;
    logic [3:0]    src, dst;

`ifdef SWITCH_RX_STATS_EN
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;
    logic [31:0]   byte_cnt_q, byte_cnt_d;
`endif

    // Header check: source must be this port, destination one-hot and not ourselves.
    always_comb begin
        src       = in_data[7:4];
        dst       = in_data[3:0];
        hdr_legal = (src == 4'(1 << PORT_ID)) && (dst != 4'd0) &&
                    ((dst & (dst - 4'd1)) == 4'd0) && (dst != src);
    end

    // Ready depends only on registered state; PASS keeps one entry spare for a closing beat.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = (count_q < CW'(FIFO_DEPTH));
            PASS:    in_ready = (count_q <= CW'(FIFO_DEPTH - 2));
            DROP:    in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
        if (rst) in_ready = 1'b0;
    end

    // Per-beat decision: what to write, where the FSM goes, and which events fire.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d   = state_q;
        push      = 1'b0;
        wr_entry  = '0;
        drop_evt  = 1'b0;
        err_evt   = 1'b0;
        legal_eop = 1'b0;
        accept    = in_valid && in_ready;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!in_sop) begin
                        err_evt = 1'b1;
                    end else if (hdr_legal) begin
                        push          = 1'b1;
                        wr_entry.sop  = 1'b1;
                        wr_entry.eop  = in_eop;
                        wr_entry.data = in_data;
                        legal_eop     = in_eop;
                        state_d       = in_eop ? IDLE : PASS;
                    end else begin
                        drop_evt = 1'b1;
                        err_evt  = 1'b1;
                        state_d  = in_eop ? IDLE : DROP;
                    end
                end
                PASS: begin
                    push = 1'b1;
                    if (!in_sop) begin
                        wr_entry.eop  = in_eop;
                        wr_entry.data = in_data;
                        legal_eop     = in_eop;
                        if (in_eop) state_d = IDLE;
                    end else begin
                        // Truncated packet: close it with an error beat, discard the new header.
                        wr_entry.eop = 1'b1;
                        wr_entry.err = 1'b1;
                        drop_evt     = 1'b1;
                        err_evt      = 1'b1;
                        state_d      = in_eop ? IDLE : DROP;
                    end
                end
                DROP: begin
                    if (in_eop) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FIFO bookkeeping and saturating drop counter.
    always_comb begin
        pop         = (count_q != '0) && out_ready;
        count_d     = count_q + CW'(push) - CW'(pop);
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        drop_cnt_d  = (drop_evt && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
        err_pulse_d = err_evt;
`ifdef SWITCH_RX_STATS_EN
        pkt_cnt_d   = pkt_cnt_q + 16'(legal_eop);
        byte_cnt_d  = byte_cnt_q + 32'(push && !wr_entry.err);
`endif
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_cnt_q  <= '0;
            err_pulse_q <= 1'b0;
`ifdef SWITCH_RX_STATS_EN
            pkt_cnt_q   <= '0;
            byte_cnt_q  <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_cnt_q  <= drop_cnt_d;
            err_pulse_q <= err_pulse_d;
`ifdef SWITCH_RX_STATS_EN
            pkt_cnt_q   <= pkt_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
`endif
        end
    end

    // FIFO storage write port.
    // NOTE: storage is not reset; count_q marks which entries hold valid data.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_entry;
    end

    assign head      = mem[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_sop   = out_valid && head.sop;
    assign out_eop   = out_valid && head.eop;
    assign out_err   = out_valid && head.err;
    assign out_data  = out_valid ? head.data : '0;
    assign drop_cnt  = drop_cnt_q;
    assign err_pulse = err_pulse_q;
`ifdef SWITCH_RX_STATS_EN
    assign pkt_cnt   = pkt_cnt_q;
    assign byte_cnt  = byte_cnt_q;
`endif

endmodule
